// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: state, command and direction encodings shared by the scheduler
// Exposes state_t (C_S codes), cmd_t (DDR command codes) and RD_OP/WR_OP.
package mem_sched_pkg;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    POP    = 4'd1,
    DECODE = 4'd2,
    PRE    = 4'd3,
    ACT    = 4'd4,
    ISSUE  = 4'd5
  } state_t;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_t;
  localparam logic RD_OP = 1'b0;
  localparam logic WR_OP = 1'b1;
endpackage

// File: rtl/mem_sched_top_bank_table.sv
// bank_table: per-bank open-row tracker for the open-page scheduler
// Ports: clk, rst; bank/row lookup key; set_open (open bank with row),
// set_close (close bank); hit, conflict, closed describe the looked-up bank.
module bank_table #(
  parameter int BANK_W = 3,
  parameter int ROW_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic              set_open,
  input  logic              set_close,
  output logic              hit,
  output logic              conflict,
  output logic              closed
);
  localparam int NB = 2**BANK_W;
  logic [NB-1:0]    is_open;
  logic [ROW_W-1:0] rows [NB];
  always_ff @(posedge clk)
    if (rst) begin
      is_open <= '0;
      rows    <= '{default: '0};
    end else if (set_open) begin
      is_open[bank] <= 1'b1;
      rows[bank]    <= row;
    end else if (set_close)
      is_open[bank] <= 1'b0;
  always_comb begin
    closed   = !is_open[bank];
    hit      = is_open[bank] && rows[bank] == row;
    conflict = is_open[bank] && rows[bank] != row;
  end
endmodule

// File: rtl/mem_sched_top.sv
// mem_sched_top: read/write arbiter with per-bank open-row PRE/ACT/RD/WR sequencing
// Ports: clk, rst; rd_adrs/wr_adrs queue heads with rd_mt/wr_mt empty flags;
// q_busy back-pressure; rd_en/wr_en pops; rw direction; valid RD/WR strobe;
// cmd command code; C_S state code; adrs_out latched request address.
import mem_sched_pkg::*;
module mem_sched_top #(
  parameter int ADDR_W   = 32,
  parameter int COL_W    = 10,
  parameter int BANK_W   = 3,
  parameter int T_ACT    = 8,
  parameter int T_PRE    = 8,
  parameter int RW_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_adrs,
  input  logic [ADDR_W-1:0] wr_adrs,
  input  logic              rd_mt,
  input  logic              wr_mt,
  input  logic              q_busy,
  output logic              rd_en,
  output logic              wr_en,
  output logic              rw,
  output logic              valid,
  output logic [2:0]        cmd,
  output logic [3:0]        C_S,
  output logic [ADDR_W-1:0] adrs_out
);
  localparam int ROW_W = ADDR_W - COL_W - BANK_W;
  localparam int TMAX  = T_ACT > T_PRE ? T_ACT : T_PRE;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int SW    = $clog2(RW_LIMIT + 1);
  localparam logic [TW-1:0] PRE_LD = TW'(T_PRE - 1);
  localparam logic [TW-1:0] ACT_LD = TW'(T_ACT - 1);
  localparam logic [SW-1:0] LIM    = SW'(RW_LIMIT);
  state_t        state, nxt;
  logic          op, nxt_op, last_op;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          hit, conflict, closed, pre_first, act_first;
  // The timer is loaded on entry, so its load value marks the first cycle.
  assign pre_first = state == PRE && timer == PRE_LD;
  assign act_first = state == ACT && timer == ACT_LD;
  // Stick with the last direction until the streak hits the limit, then yield.
  assign nxt_op = rd_mt ? WR_OP : wr_mt ? RD_OP : (streak < LIM ? last_op : ~last_op);
  bank_table #(.BANK_W(BANK_W), .ROW_W(ROW_W)) u_bank_table (
    .clk      (clk),
    .rst      (rst),
    .bank     (adrs_out[COL_W+BANK_W-1:COL_W]),
    .row      (adrs_out[ADDR_W-1:COL_W+BANK_W]),
    .set_open (act_first),
    .set_close(pre_first),
    .hit      (hit),
    .conflict (conflict),
    .closed   (closed)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (rd_mt && wr_mt) ? IDLE : POP;
      POP:     nxt = DECODE;
      DECODE:  nxt = hit ? ISSUE : closed ? ACT : conflict ? PRE : DECODE;
      PRE:     nxt = timer == '0 ? ACT : PRE;
      ACT:     nxt = timer == '0 ? ISSUE : ACT;
      ISSUE:   nxt = q_busy ? ISSUE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    rd_en = state == POP && op == RD_OP;
    wr_en = state == POP && op == WR_OP;
    rw    = state != IDLE && op;
    valid = state == ISSUE && !q_busy;
    cmd   = pre_first ? CMD_PRE : act_first ? CMD_ACT : valid ? (op ? CMD_WR : CMD_RD) : CMD_NOP;
    C_S   = state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      op       <= RD_OP;
      last_op  <= RD_OP;
      streak   <= '0;
      timer    <= '0;
      adrs_out <= '0;
    end else begin
      if (state == IDLE) op <= nxt_op;
      if (state == POP) begin
        adrs_out <= op ? wr_adrs : rd_adrs;
        last_op  <= op;
        streak   <= op != last_op ? SW'(1) : streak == LIM ? streak : streak + 1'b1;
      end
      timer <= (nxt == PRE && state != PRE) ? PRE_LD :
               (nxt == ACT && state != ACT) ? ACT_LD :
               timer == '0 ? timer : timer - 1'b1;
    end
endmodule
